// File: rtl/etherparse_axis_pkg.sv
// Shared AXI-stream helpers for the etherparse egress path.
//  - axis_beat_t   : default-width beat (data/last/user) for blocks using the stock widths
//  - FRAME_MODE_*  : frame forwarding mode selectors
//  - rel_state_t   : oversize-frame release state
//  - sat_inc       : saturating increment for statistics counters (up to SAT_W bits)
package etherparse_axis_pkg;

  localparam int unsigned AXIS_DATA_W    = 64;
  localparam int unsigned AXIS_USER_W    = 1;
  localparam int unsigned FRAME_MODE_CUT = 0;
  localparam int unsigned FRAME_MODE_SAF = 1;
  localparam int unsigned SAT_W          = 64;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic                   last;
    logic [AXIS_USER_W-1:0] user;
  } axis_beat_t;

  typedef enum logic {
    REL_IDLE   = 1'b0,
    REL_ACTIVE = 1'b1
  } rel_state_t;

  // Callers zero-extend their counter and pass the all-ones value of its real width.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max);
    return (v >= max) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_fifo_core.sv
// FWFT FIFO core: storage array, extra-bit pointers, occupancy and a registered head.
// Ports:
//  clk, rst                    clock, synchronous active-high reset
//  wr_en, wr_data/last/user    write strobe and beat (caller guarantees !full)
//  full                        occupancy == DEPTH
//  rd_en                       pop the head (caller guarantees rd_valid)
//  rd_valid, rd_data/last/user registered head of queue
//  occupancy                   words stored, including the head
module axis_fifo_core #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_last,
  input  logic [USER_WIDTH-1:0]    wr_user,
  output logic                     full,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_last,
  output logic [USER_WIDTH-1:0]    rd_user,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  beat_t       mem [DEPTH];
  beat_t       wr_beat;
  beat_t       head_q;
  beat_t       head_nxt;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr_nxt;
  logic [AW:0] rd_ptr_nxt;
  logic [AW:0] occ_nxt;
  logic        valid_q;

  assign wr_beat    = '{data: wr_data, last: wr_last, user: wr_user};
  assign occupancy  = wr_ptr - rd_ptr;
  assign full       = (occupancy == (AW+1)'(DEPTH));
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_en};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_en};
  assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;

  // The head register is reloaded every cycle from the slot the read pointer will
  // point at. If that slot is the one being written now, take the incoming beat
  // directly so a push into an (effectively) empty FIFO shows up next cycle.
  always_comb begin
    head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = wr_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      valid_q <= (occ_nxt != '0);
      head_q  <= head_nxt;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = head_q.data;
  assign rd_last  = head_q.last;
  assign rd_user  = head_q.user;

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) wr_en |-> !full);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) rd_en |-> valid_q);
  a_occ_bound:    assert property (@(posedge clk) disable iff (rst) occupancy <= (AW+1)'(DEPTH));
`endif

endmodule

// File: rtl/axis_egress_fifo.sv
// AXI-stream egress boundary with a DEPTH-entry FWFT FIFO, optional store-and-forward
// gating and statistics.
// Ports:
//  clk, rst                           clock, synchronous active-high reset
//  s_tdata/tvalid/tready/tlast/tuser  internal stream (s_tready from registered state only)
//  m_tdata/tvalid/tready/tlast/tuser  external stream (registered beat)
//  occupancy                          words currently stored
//  frames_out                         tlast beats accepted on m_* (saturating)
//  stall_cycles                       cycles with m_tvalid && !m_tready (saturating)
module axis_egress_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FRAME_MODE = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  input  logic [USER_WIDTH-1:0]  s_tuser,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [USER_WIDTH-1:0]  m_tuser,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_WIDTH-1:0]   frames_out,
  output logic [CNT_WIDTH-1:0]   stall_cycles
);

  import etherparse_axis_pkg::*;

  localparam int unsigned     OW      = $clog2(DEPTH) + 1;
  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_WIDTH{1'b1}});

  logic ready_en;
  logic full;
  logic push;
  logic pop;
  logic core_valid;

  assign s_tready = ready_en && !full;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  axis_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (USER_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push),
    .wr_data   (s_tdata),
    .wr_last   (s_tlast),
    .wr_user   (s_tuser),
    .full      (full),
    .rd_en     (pop),
    .rd_valid  (core_valid),
    .rd_data   (m_tdata),
    .rd_last   (m_tlast),
    .rd_user   (m_tuser),
    .occupancy (occupancy)
  );

  generate
    if (FRAME_MODE == FRAME_MODE_SAF) begin : g_saf
      logic [OW-1:0] frames_held;
      rel_state_t    rel_state;
      rel_state_t    rel_state_nxt;

      always_ff @(posedge clk) begin
        if (rst) begin
          frames_held <= '0;
          rel_state   <= REL_IDLE;
        end else begin
          rel_state <= rel_state_nxt;
          case ({push && s_tlast, pop && m_tlast})
            2'b10:   frames_held <= frames_held + 1'b1;
            2'b01:   frames_held <= frames_held - 1'b1;
            default: frames_held <= frames_held;
          endcase
        end
      end

      // A frame larger than the FIFO can never complete in storage: once full with no
      // whole frame held, fall back to cut-through until that frame's tlast leaves.
      always_comb begin
        rel_state_nxt = rel_state;
        case (rel_state)
          REL_IDLE:   if (full && (frames_held == '0)) rel_state_nxt = REL_ACTIVE;
          REL_ACTIVE: if (pop && m_tlast)              rel_state_nxt = REL_IDLE;
          default:    rel_state_nxt = REL_IDLE;
        endcase
      end

      assign m_tvalid = core_valid &&
                        ((frames_held != '0) || full || (rel_state == REL_ACTIVE));
    end else begin : g_cut
      assign m_tvalid = core_valid;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en     <= 1'b0;
      frames_out   <= '0;
      stall_cycles <= '0;
    end else begin
      ready_en <= 1'b1;
      if (pop && m_tlast) begin
        frames_out <= CNT_WIDTH'(sat_inc(SAT_W'(frames_out), CNT_MAX));
      end
      if (m_tvalid && !m_tready) begin
        stall_cycles <= CNT_WIDTH'(sat_inc(SAT_W'(stall_cycles), CNT_MAX));
      end
    end
  end

`ifndef SYNTHESIS
  a_m_stable: assert property (@(posedge clk) disable iff (rst)
    (m_tvalid && !m_tready) |=> (m_tvalid && $stable({m_tdata, m_tlast, m_tuser})));
`endif

endmodule
